// File: rtl/button_debouncer.sv
// Push-button conditioning: per-button synchronizer and debounce counter, followed
// by a registered one-hot press strobe that turns simultaneous presses into a collision flag.
module button_debouncer #(
  parameter int N_B             = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N_B-1:0] i_buttons,
  output logic [N_B-1:0] o_level,
  output logic [N_B-1:0] o_buttons,
  output logic           o_collision
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(N_B + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_B-1:0]         sync1_q;
  logic [N_B-1:0]         sync2_q;
  logic [N_B-1:0]         stable_q;
  logic [N_B-1:0]         stable_d;
  logic [N_B-1:0][CW-1:0] cnt_q;
  logic [N_B-1:0][CW-1:0] cnt_d;
  logic [N_B-1:0]         p_q;
  logic [N_B-1:0]         p_d;
  logic [N_B-1:0]         btn_q;
  logic [N_B-1:0]         btn_d;
  logic                   col_q;
  logic                   col_d;
  logic [PW-1:0]          pcnt;

  // A disagreement must persist for DEBOUNCE_CYCLES consecutive edges; any
  // agreement in between throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    p_d      = '0;
    for (int i = 0; i < N_B; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        p_d[i]      = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < N_B; i++) begin
      pcnt = pcnt + PW'(p_q[i]);
    end
    btn_d = (pcnt == PW'(1)) ? p_q : '0;
    col_d = (pcnt > PW'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      btn_q    <= '0;
      col_q    <= 1'b0;
    end else begin
      sync1_q  <= i_buttons;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      btn_q    <= btn_d;
      col_q    <= col_d;
    end
  end

  assign o_level     = stable_q;
  assign o_buttons   = btn_q;
  assign o_collision = col_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES = 4; every edge of each
// scenario is compared against hand-derived {level, strobe, collision} values.
module tb_button_debouncer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] i_buttons = 3'b000;
  logic [2:0] o_level;
  logic [2:0] o_buttons;
  logic       o_collision;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_v;
  logic [6:0] got_v;

  button_debouncer #(.N_B(3), .DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_buttons  (i_buttons),
    .o_level    (o_level),
    .o_buttons  (o_buttons),
    .o_collision(o_collision)
  );

  always #5 clock = ~clock;

  // One rising edge, then return at the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [2:0] btn);
    i_buttons = btn;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    i_buttons = 3'b111;
    reset = 1'b1;
    tick();
    tick();
    got_v = {o_level, o_buttons, o_collision};
    total++;
    if (got_v !== 7'b000_000_0) begin
      bad++;
      $display("FAIL reset_values got=%b exp=%b", got_v, 7'b0);
    end
    reset = 1'b0;
    // Buttons held through reset: all three accepted together -> collision.
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b111 : 3'b000, 3'b000, (e == 6)};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_held e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset(3'b000);
    i_buttons = 3'b100;
    for (int e = 0; e <= 14; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b100 : 3'b000, (e == 6) ? 3'b100 : 3'b000, 1'b0};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL clean_press e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset(3'b000);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        i_buttons = (r % 2 == 0) ? 3'b010 : 3'b000;
        tick();
        got_v = {o_level, o_buttons, o_collision};
        total++;
        if (got_v !== 7'b0) begin
          bad++;
          $display("FAIL bounce_toggle r=%0d k=%0d got=%b exp=%b", r, k, got_v, 7'b0);
        end
      end
    end
    i_buttons = 3'b010;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b010 : 3'b000, (e == 6) ? 3'b010 : 3'b000, 1'b0};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL bounce_settle e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  // Continues from test_bounce with button 1 accepted and held.
  task automatic test_release();
    i_buttons = 3'b000;
    for (int e = 0; e <= 9; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b000 : 3'b010, 3'b000, 1'b0};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL release e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_collision();
    do_reset(3'b000);
    i_buttons = 3'b101;
    for (int e = 0; e <= 9; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b101 : 3'b000, 3'b000, (e == 6)};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL collision e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] lvl;
    logic [2:0] btn;
    do_reset(3'b000);
    i_buttons = 3'b001;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 0) i_buttons = 3'b011;
      lvl = {1'b0, (e >= 6), (e >= 5)};
      btn = (e == 6) ? 3'b001 : (e == 7) ? 3'b010 : 3'b000;
      exp_v = {lvl, btn, 1'b0};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL back_to_back e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset(3'b000);
    i_buttons = 3'b001;
    for (int e = 0; e <= 2; e++) begin
      tick();
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== 7'b0) begin
        bad++;
        $display("FAIL midrst_pre e=%0d got=%b exp=%b", e, got_v, 7'b0);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got_v = {o_level, o_buttons, o_collision};
    total++;
    if (got_v !== 7'b0) begin
      bad++;
      $display("FAIL midrst_at got=%b exp=%b", got_v, 7'b0);
    end
    for (int e = 0; e <= 9; e++) begin
      tick();
      exp_v = {(e >= 5) ? 3'b001 : 3'b000, (e == 6) ? 3'b001 : 3'b000, 1'b0};
      got_v = {o_level, o_buttons, o_collision};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL midrst_post e=%0d got=%b exp=%b", e, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_collision();
    test_back_to_back();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
